julia_pixel_scheduler: RTL and testbench

Frame-level controller for the Julia set renderer. It raster-scans the VGA pixel grid and generates the complex start coordinate for each pixel incrementally. It dispatches each pixel to one of NUM_ENG iteration engines over per-engine valid/ready, then arbitrates engine results onto the single frame-buffer write port. It sits between the top-level config logic (SW/KEY) and the engine array plus SRAM writer.

---
 rtl/julia_pixel_scheduler_pkg.sv | 23 ++
 rtl/julia_pixel_scheduler_if.sv | 36 +++
 rtl/julia_pixel_scheduler_rr_arbiter.sv | 42 ++++
 rtl/julia_pixel_scheduler.sv | 150 +++++++++++++++
 tb/tb_julia_pixel_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/julia_pixel_scheduler_pkg.sv
// Shared constants and the scheduler state encoding for the Julia renderer
// frame controller.
package julia_pkg;

  localparam int COORD_W = 18;
  localparam int ITER_W  = 8;
  localparam int X_RES   = 640;
  localparam int Y_RES   = 480;
  localparam int ADDR_W  = 19;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE
  } sched_state_t;

  // Index width that stays legal for degenerate single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/julia_pixel_scheduler_if.sv
// Engine dispatch, engine result and frame-buffer write signals between the
// pixel scheduler (master) and the engine array / SRAM writer (slave).
interface julia_pixel_scheduler_if #(
  parameter int NUM_ENG = 4,
  parameter int COORD_W = julia_pkg::COORD_W,
  parameter int ITER_W  = julia_pkg::ITER_W,
  parameter int ADDR_W  = julia_pkg::ADDR_W
);

  logic [NUM_ENG-1:0]             eng_req_valid;
  logic [NUM_ENG-1:0]             eng_req_ready;
  logic [COORD_W-1:0]             eng_x;
  logic [COORD_W-1:0]             eng_y;
  logic [ADDR_W-1:0]              eng_addr;
  logic [NUM_ENG-1:0]             eng_res_valid;
  logic [NUM_ENG-1:0][ADDR_W-1:0] eng_res_addr;
  logic [NUM_ENG-1:0][ITER_W-1:0] eng_res_iter;
  logic [NUM_ENG-1:0]             eng_res_ack;
  logic                           fb_we;
  logic [ADDR_W-1:0]              fb_addr;
  logic [ITER_W-1:0]              fb_data;
  logic                           fb_ready;

  modport master (
    output eng_req_valid, eng_x, eng_y, eng_addr, eng_res_ack,
    output fb_we, fb_addr, fb_data,
    input  eng_req_ready, eng_res_valid, eng_res_addr, eng_res_iter, fb_ready
  );

  modport slave (
    input  eng_req_valid, eng_x, eng_y, eng_addr, eng_res_ack,
    input  fb_we, fb_addr, fb_data,
    output eng_req_ready, eng_res_valid, eng_res_addr, eng_res_iter, fb_ready
  );

endinterface

// File: rtl/julia_pixel_scheduler_rr_arbiter.sv
// Round-robin arbiter: ptr holds the highest-priority requester; after a
// granted cycle with advance high it moves to the engine after the winner.
module rr_arbiter import julia_pkg::*; #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = idx_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] cand;

  // Scan farthest offset first so the nearest requester overwrites the rest.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && |grant) begin
      ptr <= PW'((int'(gidx) + 1) % N);
    end
  end

endmodule

// File: rtl/julia_pixel_scheduler.sv
// Raster-scans the pixel grid, hands each pixel's start coordinate to a free
// iteration engine and funnels engine results onto the frame-buffer port.
module julia_pixel_scheduler import julia_pkg::*; #(
  parameter int NUM_ENG = 4,
  parameter int X_RES   = julia_pkg::X_RES,
  parameter int Y_RES   = julia_pkg::Y_RES,
  parameter int COORD_W = julia_pkg::COORD_W,
  parameter int ITER_W  = julia_pkg::ITER_W,
  parameter int ADDR_W  = julia_pkg::ADDR_W
) (
  input  logic                 clk_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COORD_W-1:0]   cfg_x0,
  input  logic [COORD_W-1:0]   cfg_y0,
  input  logic [COORD_W-1:0]   cfg_step,
  output logic                 busy,
  output logic                 frame_done,
  julia_pixel_scheduler_if.master bus
);

  localparam int XW = idx_w(X_RES);
  localparam int YW = idx_w(Y_RES);
  localparam int OW = $clog2(NUM_ENG + 1);

  sched_state_t state, state_nxt;

  logic [COORD_W-1:0] x0_q, step_q;
  logic [COORD_W-1:0] cur_re, cur_im;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [ADDR_W-1:0]  addr;
  logic [OW-1:0]      outstanding;

  logic [NUM_ENG-1:0] disp_gnt, wb_gnt;
  logic               disp_hs, wb_ack, last_px, x_end;
  logic [ADDR_W-1:0]  wb_addr;
  logic [ITER_W-1:0]  wb_data;

  // Dispatch grants only ready engines, so every grant is a completed handshake.
  rr_arbiter #(.N(NUM_ENG)) u_disp_arb (
    .clk     (clk_50),
    .reset   (reset),
    .req     (bus.eng_req_ready & {NUM_ENG{state == DISPATCH}}),
    .advance (1'b1),
    .grant   (disp_gnt)
  );

  rr_arbiter #(.N(NUM_ENG)) u_wb_arb (
    .clk     (clk_50),
    .reset   (reset),
    .req     (bus.eng_res_valid & {NUM_ENG{state != IDLE}}),
    .advance (bus.fb_ready),
    .grant   (wb_gnt)
  );

  assign disp_hs = |disp_gnt;
  assign wb_ack  = (|wb_gnt) & bus.fb_ready;
  assign x_end   = (x == XW'(X_RES - 1));
  assign last_px = x_end && (y == YW'(Y_RES - 1));

  assign bus.eng_req_valid = disp_gnt;
  assign bus.eng_x         = cur_re;
  assign bus.eng_y         = cur_im;
  assign bus.eng_addr      = addr;
  assign bus.eng_res_ack   = wb_gnt & {NUM_ENG{bus.fb_ready}};
  assign bus.fb_we         = wb_ack;
  assign bus.fb_addr       = wb_addr;
  assign bus.fb_data       = wb_data;

  always_comb begin
    wb_addr = '0;
    wb_data = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (wb_gnt[i]) begin
        wb_addr = bus.eng_res_addr[i];
        wb_data = bus.eng_res_iter[i];
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = DISPATCH;
      end
      DISPATCH: if (disp_hs && last_px) state_nxt = DRAIN;
      DRAIN:    if (outstanding == '0) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coordinates advance incrementally; wrap modulo 2^COORD_W is intended.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      x0_q   <= '0;
      step_q <= '0;
      cur_re <= '0;
      cur_im <= '0;
      x      <= '0;
      y      <= '0;
      addr   <= '0;
    end else if (state == IDLE && start) begin
      x0_q   <= cfg_x0;
      step_q <= cfg_step;
      cur_re <= cfg_x0;
      cur_im <= cfg_y0;
      x      <= '0;
      y      <= '0;
      addr   <= '0;
    end else if (disp_hs) begin
      addr <= addr + 1'b1;
      if (x_end) begin
        x      <= '0;
        y      <= y + 1'b1;
        cur_re <= x0_q;
        cur_im <= cur_im - step_q;
      end else begin
        x      <= x + 1'b1;
        cur_re <= cur_re + step_q;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({disp_hs, wb_ack})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// Directed and randomized frames on a 4x3 grid with two engines, checked
// against a pixel-level model of dispatch order, coordinates and writeback.
module tb_julia_pixel_scheduler;

  localparam int NE  = 2;
  localparam int XR  = 4;
  localparam int YR  = 3;
  localparam int NPX = XR * YR;
  localparam int CW  = 18;
  localparam int IW  = 8;
  localparam int AW  = 19;

  logic          clk_50 = 1'b0;
  logic          reset  = 1'b0;
  logic          start  = 1'b0;
  logic [CW-1:0] cfg_x0 = '0, cfg_y0 = '0, cfg_step = '0;
  logic          busy, frame_done;

  julia_pixel_scheduler_if #(.NUM_ENG(NE), .COORD_W(CW), .ITER_W(IW), .ADDR_W(AW)) bus ();

  julia_pixel_scheduler #(
    .NUM_ENG(NE), .X_RES(XR), .Y_RES(YR), .COORD_W(CW), .ITER_W(IW), .ADDR_W(AW)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .start      (start),
    .cfg_x0     (cfg_x0),
    .cfg_y0     (cfg_y0),
    .cfg_step   (cfg_step),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk_50 = ~clk_50;

  int checks = 0, errors = 0;
  // phase: 0 idle, 1 dispatching, 2 draining, 3 done
  int phase, n, d_ptr, w_ptr, m_out;
  int writes, dones, g1_seen, lat_lo, lat_hi, fb_mode;
  int e_addr[NE], e_cnt[NE];
  bit e_busy[NE], e_allow[NE];
  bit written[NPX];
  bit start_req, rst_req, plan_cfg;
  logic [CW-1:0] lx0, ly0, lstep;

  function automatic int rr_pick(bit [NE-1:0] req, int ptr);
    for (int k = 0; k < NE; k++) begin
      int j = (ptr + k) % NE;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [IW-1:0] iter_of(int a);
    return IW'(a * 37 + 5);
  endfunction

  function automatic logic [CW-1:0] exp_re(int p);
    return CW'(int'(lx0) + (p % XR) * int'(lstep));
  endfunction

  function automatic logic [CW-1:0] exp_im(int p);
    return CW'(int'(ly0) - (p / XR) * int'(lstep));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    phase = 0; n = 0; d_ptr = 0; w_ptr = 0; m_out = 0;
    for (int e = 0; e < NE; e++) begin
      e_busy[e] = 1'b0; e_addr[e] = 0; e_cnt[e] = 0;
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_req_valid"},  bus.eng_req_valid, 0);
    chk({tag, "_res_ack"},    bus.eng_res_ack, 0);
    chk({tag, "_fb_we"},      bus.fb_we, 0);
    chk({tag, "_eng_x"},      bus.eng_x, 0);
    chk({tag, "_eng_y"},      bus.eng_y, 0);
    chk({tag, "_eng_addr"},   bus.eng_addr, 0);
    chk({tag, "_fb_addr"},    bus.fb_addr, 0);
    chk({tag, "_fb_data"},    bus.fb_data, 0);
  endtask

  // One clock: drive engine/writer inputs, check outputs mid-cycle, then
  // advance the model with the handshakes that occur at the edge.
  task automatic step();
    bit [NE-1:0] rdy, rv, exp_req, exp_ack;
    int gi, wi, nxt;
    bit we;
    for (int e = 0; e < NE; e++) begin
      rdy[e] = !e_busy[e] && e_allow[e];
      rv[e]  = e_busy[e] && (e_cnt[e] == 0);
      bus.eng_res_addr[e] = AW'(e_addr[e]);
      bus.eng_res_iter[e] = iter_of(e_addr[e]);
    end
    bus.eng_req_ready = rdy;
    bus.eng_res_valid = rv;
    bus.fb_ready = (fb_mode == 0) ? 1'b1 : (fb_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    start = start_req;
    reset = !rst_req;
    @(negedge clk_50);
    gi = (phase == 1) ? rr_pick(rdy, d_ptr) : -1;
    wi = (phase != 0) ? rr_pick(rv, w_ptr) : -1;
    we = (wi >= 0) && bus.fb_ready;
    exp_req = '0;
    exp_ack = '0;
    if (gi >= 0) exp_req[gi] = 1'b1;
    if (we) exp_ack[wi] = 1'b1;
    chk("req_valid", bus.eng_req_valid, exp_req);
    chk("res_ack", bus.eng_res_ack, exp_ack);
    chk("fb_we", bus.fb_we, we);
    chk("busy", busy, phase != 0);
    chk("frame_done", frame_done, phase == 3);
    chk("outstanding", dut.outstanding, m_out);
    if (gi >= 0) begin
      chk("eng_addr", bus.eng_addr, n);
      chk("eng_x", bus.eng_x, exp_re(n));
      chk("eng_y", bus.eng_y, exp_im(n));
      if (plan_cfg && n == 4) begin
        chk("px4_x", bus.eng_x, 18'h38000);
        chk("px4_y", bus.eng_y, 18'h03000);
      end
      if (plan_cfg && n == 11) begin
        chk("px11_x", bus.eng_x, 18'h3B000);
        chk("px11_y", bus.eng_y, 18'h02000);
      end
    end
    if (wi >= 0) begin
      chk("fb_addr", bus.fb_addr, e_addr[wi]);
      chk("fb_data", bus.fb_data, iter_of(e_addr[wi]));
    end
    if (bus.fb_we === 1'b1) begin
      writes++;
      if (int'(bus.fb_addr) < NPX) begin
        chk("dup_write", written[int'(bus.fb_addr)], 0);
        written[int'(bus.fb_addr)] = 1'b1;
      end
    end
    if (frame_done === 1'b1) dones++;
    if (bus.eng_req_valid[1] === 1'b1) g1_seen++;
    @(posedge clk_50);
    #1;
    if (rst_req) begin
      model_clear();
      return;
    end
    nxt = phase;
    case (phase)
      0: if (start_req) begin
        lx0 = cfg_x0; ly0 = cfg_y0; lstep = cfg_step; n = 0; nxt = 1;
      end
      1: if (gi >= 0 && n == NPX - 1) nxt = 2;
      2: if (m_out == 0) nxt = 3;
      default: nxt = 0;
    endcase
    for (int e = 0; e < NE; e++)
      if (e_busy[e] && e_cnt[e] > 0) e_cnt[e]--;
    if (we) begin
      e_busy[wi] = 1'b0; w_ptr = (wi + 1) % NE; m_out--;
    end
    if (gi >= 0) begin
      e_busy[gi] = 1'b1; e_addr[gi] = n; e_cnt[gi] = $urandom_range(lat_lo, lat_hi);
      d_ptr = (gi + 1) % NE; m_out++; n++;
    end
    phase = nxt;
  endtask

  task automatic begin_frame();
    writes = 0; dones = 0; g1_seen = 0;
    for (int i = 0; i < NPX; i++) written[i] = 1'b0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
  endtask

  task automatic finish_frame(string tag);
    int cyc = 0;
    while (phase != 0 && cyc < 600) begin
      step();
      cyc++;
    end
    chk({tag, "_no_timeout"}, cyc < 600, 1);
    step();
    chk({tag, "_writes"}, writes, NPX);
    chk({tag, "_done_pulses"}, dones, 1);
  endtask

  initial begin
    bus.eng_req_ready = '0;
    bus.eng_res_valid = '0;
    bus.eng_res_addr  = '0;
    bus.eng_res_iter  = '0;
    bus.fb_ready      = 1'b0;
    model_clear();
    e_allow[0] = 1'b1; e_allow[1] = 1'b1;
    lat_lo = 3; lat_hi = 3; fb_mode = 0;
    start_req = 1'b0; rst_req = 1'b0; plan_cfg = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;
    check_zero("reset");

    cfg_x0 = 18'h38000; cfg_y0 = 18'h04000; cfg_step = 18'h01000;
    begin_frame();
    finish_frame("basic");

    e_allow[1] = 1'b0;
    begin_frame();
    finish_frame("one_engine");
    chk("one_engine_e1_grants", g1_seen, 0);
    e_allow[1] = 1'b1;

    fb_mode = 1;
    begin_frame();
    repeat (26) step();
    chk("stall_no_writes", writes, 0);
    fb_mode = 0;
    finish_frame("stall");

    begin_frame();
    repeat (4) step();
    start_req = 1'b1;
    cfg_x0 = 18'h00123;
    step();
    start_req = 1'b0;
    cfg_x0 = 18'h38000;
    finish_frame("restart_ignored");

    begin_frame();
    for (int c = 0; c < 100 && n < 7; c++) step();
    chk("abort_reached_px6", n, 7);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    reset = 1'b1;
    check_zero("abort");
    chk("abort_no_done", dones, 0);
    begin_frame();
    finish_frame("after_abort");

    plan_cfg = 1'b0;
    lat_lo = 0; lat_hi = 6; fb_mode = 2;
    for (int f = 0; f < 4; f++) begin
      cfg_x0 = CW'($urandom); cfg_y0 = CW'($urandom); cfg_step = CW'($urandom);
      e_allow[1] = 1'($urandom_range(0, 1));
      begin_frame();
      finish_frame("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
